// File: rtl/mmio_timer_bus.sv
// Data-RAM / I/O decoder for the MIPS data port: switches, hex outputs, compare timer.
// Reads are combinational (zero latency); writes land on the next rising edge; no backpressure.
module mmio_timer_bus #(
  parameter int          RAM_WORDS   = 256,
  parameter logic [31:0] IO_BASE     = 32'hFFFF_0000,
  parameter int          N_SW        = 1,
  parameter int          N_HEX       = 1,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memwrite,
  input  logic                  memread,
  input  logic [31:0]           addr,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [16*N_SW-1:0]    sw,
  output logic [16*N_HEX-1:0]   hex,
  output logic                  irq
);
  localparam int          RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  localparam logic [13:0] W_COUNT  = 14'h020;
  localparam logic [13:0] W_CMP    = 14'h021;
  localparam logic [13:0] W_CTRL   = 14'h022;
  localparam logic [13:0] W_STATUS = 14'h023;

  typedef struct packed {
    logic irq_en;
    logic autoreload;
    logic en;
  } ctrl_t;

  logic [31:0]                         ram [RAM_WORDS];
  logic [SYNC_STAGES-1:0][16*N_SW-1:0] sync_q;
  logic [N_HEX-1:0][15:0]              hex_q;
  logic [31:0]                         count_q;
  logic [31:0]                         cmp_q;
  ctrl_t                               ctrl_q;
  logic                                match_q;

  logic              ram_hit;
  logic              io_hit;
  logic              io_wr;
  logic [RAM_AW-1:0] ram_idx;
  logic [13:0]       io_word;
  logic [3:0]        chan;
  logic              sw_sel;
  logic              hex_sel;
  logic              wr_count;
  logic              wr_cmp;
  logic              wr_ctrl;
  logic              wr_status;
  logic              match_now;
  logic [31:0]       count_inc;
  logic [31:0]       rd_val;
  logic              unused_ok;

  // RAM takes precedence so an overlapping I/O base can never shadow data words.
  assign ram_hit = (addr < RAM_BYTES);
  assign io_hit  = !ram_hit && (addr[31:16] == IO_BASE[31:16]);
  assign io_wr   = memwrite && io_hit;
  assign ram_idx = addr[RAM_AW+1:2];
  assign io_word = addr[15:2];
  assign chan    = io_word[3:0];
  assign sw_sel  = (io_word[13:4] == 10'd0);
  assign hex_sel = (io_word[13:4] == 10'd1);

  assign wr_count  = io_wr && (io_word == W_COUNT);
  assign wr_cmp    = io_wr && (io_word == W_CMP);
  assign wr_ctrl   = io_wr && (io_word == W_CTRL);
  assign wr_status = io_wr && (io_word == W_STATUS) && writedata[0];

  assign match_now = ctrl_q.en && (count_q == cmp_q);
  assign count_inc = count_q + 32'd1;

  assign hex       = hex_q;
  assign irq       = match_q && ctrl_q.irq_en;
  assign unused_ok = &{1'b0, addr[1:0]};

  always_ff @(posedge clk) begin
    if (memwrite && ram_hit) begin
      ram[ram_idx] <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= sw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q <= '0;
    end else begin
      for (int i = 0; i < N_HEX; i++) begin
        if (io_wr && hex_sel && (chan == 4'(i))) begin
          hex_q[i] <= writedata[15:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      ctrl_q  <= '0;
      match_q <= 1'b0;
    end else begin
      if (wr_count) begin
        count_q <= writedata;
      end else if (match_now) begin
        count_q <= ctrl_q.autoreload ? 32'd0 : count_inc;
      end else if (ctrl_q.en) begin
        count_q <= count_inc;
      end

      if (wr_cmp) begin
        cmp_q <= writedata;
      end
      if (wr_ctrl) begin
        ctrl_q <= ctrl_t'(writedata[2:0]);
      end

      // A match on the same edge as a write-1-to-clear keeps the flag set.
      if (match_now) begin
        match_q <= 1'b1;
      end else if (wr_status) begin
        match_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (ram_hit) begin
      rd_val = ram[ram_idx];
    end else if (io_hit) begin
      if (sw_sel) begin
        for (int i = 0; i < N_SW; i++) begin
          if (chan == 4'(i)) begin
            rd_val = {16'h0000, sync_q[SYNC_STAGES-1][16*i +: 16]};
          end
        end
      end else if (hex_sel) begin
        for (int i = 0; i < N_HEX; i++) begin
          if (chan == 4'(i)) begin
            rd_val = {16'h0000, hex_q[i]};
          end
        end
      end else begin
        case (io_word)
          W_COUNT:  rd_val = count_q;
          W_CMP:    rd_val = cmp_q;
          W_CTRL:   rd_val = {29'd0, ctrl_q};
          W_STATUS: rd_val = {31'd0, match_q};
          default:  rd_val = '0;
        endcase
      end
    end
  end

  assign readdata = memread ? rd_val : 32'd0;

endmodule
